// File: rtl/rice_stream_decoder.sv
// Rice residual stream decoder: reads 16-bit words MSB first from RAM and decodes
// unary-quotient / k-bit-remainder / zigzag codes into signed 16-bit residuals.
module rice_stream_decoder (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iStart,
  input  logic [3:0]  iRiceParam,
  input  logic [15:0] iCount,
  output logic        oRamReadEnable,
  output logic [15:0] oRamAddress,
  input  logic [15:0] iRamData,
  output logic [15:0] oResidual,
  output logic        oValid,
  output logic        oDone,
  output logic        oError
);

  typedef enum logic [2:0] {StIdle, StFill, StUnary, StBin, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [15:0] count_q, count_d;
  logic [15:0] emitted_q, emitted_d;
  // One bit wider than a word: with k = 0 the quotient limit is 65536.
  logic [16:0] quot_q, quot_d;
  logic [15:0] rem_q, rem_d;
  logic [3:0]  bin_cnt_q, bin_cnt_d;
  logic [15:0] cur_q, cur_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [15:0] pf_q, pf_d;
  logic        pf_valid_q, pf_valid_d;
  logic        rd_pend_q, rd_pend_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] residual_q, residual_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;

  logic        read_en;
  logic        cur_bit;
  logic        emit;
  logic [16:0] quot_inc;
  logic [16:0] quot_limit;
  logic [15:0] rem_shift;
  logic [15:0] code_u;

  // Next-state: FSM, bit consumption, read issue and read-data capture.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    count_d    = count_q;
    emitted_d  = emitted_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    bin_cnt_d  = bin_cnt_q;
    cur_d      = cur_q;
    bit_idx_d  = bit_idx_q;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    addr_d     = addr_q;
    residual_d = residual_q;
    valid_d    = valid_q;
    error_d    = error_q;
    read_en    = 1'b0;
    emit       = 1'b0;
    code_u     = '0;
    cur_bit    = cur_q[bit_idx_q];
    quot_inc   = quot_q + 17'd1;
    quot_limit = 17'd1 << (5'd16 - {1'b0, k_q});
    rem_shift  = {rem_q[14:0], cur_bit};

    if (iEnable) begin
      // A pending pulse held through a stall is dropped only on an enabled cycle.
      valid_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iStart) begin
            k_d        = iRiceParam;
            count_d    = iCount;
            emitted_d  = '0;
            quot_d     = '0;
            rem_d      = '0;
            bin_cnt_d  = '0;
            addr_d     = '0;
            pf_valid_d = 1'b0;
            bit_idx_d  = 4'd15;
            error_d    = 1'b0;
            if (iRiceParam == 4'd15) begin
              error_d = 1'b1;
              state_d = StDone;
            end else if (iCount == 16'd0) begin
              state_d = StDone;
            end else begin
              state_d = StFill;
            end
          end
        end
        StFill: begin
          // Words 0 and 1 go out back to back; word 0 lands in the current register.
          read_en = (addr_q < 16'd2);
        end
        StUnary, StBin: begin
          if (state_q == StUnary && emitted_q == count_q) begin
            // Count reached: no further bits and no further prefetch.
            state_d = StDone;
          end else begin
            read_en = !pf_valid_q && !rd_pend_q;
            if (bit_idx_q == 4'd0) begin
              cur_d      = pf_q;
              pf_valid_d = 1'b0;
              bit_idx_d  = 4'd15;
            end else begin
              bit_idx_d = bit_idx_q - 4'd1;
            end
            if (state_q == StUnary) begin
              if (cur_bit) begin
                if (k_q == 4'd0) begin
                  emit   = 1'b1;
                  code_u = quot_q[15:0];
                end else begin
                  state_d   = StBin;
                  bin_cnt_d = k_q;
                end
              end else begin
                quot_d = quot_inc;
                if (quot_inc == quot_limit) begin
                  error_d = 1'b1;
                  state_d = StDone;
                end
              end
            end else begin
              rem_d     = rem_shift;
              bin_cnt_d = bin_cnt_q - 4'd1;
              if (bin_cnt_q == 4'd1) begin
                emit    = 1'b1;
                code_u  = (quot_q[15:0] << k_q) | rem_shift;
                state_d = StUnary;
              end
            end
          end
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    if (emit) begin
      valid_d    = 1'b1;
      // Zigzag unfold: even codes are non-negative, odd codes negative.
      residual_d = {1'b0, code_u[15:1]} ^ {16{code_u[0]}};
      emitted_d  = emitted_q + 16'd1;
      quot_d     = '0;
      rem_d      = '0;
    end

    if (read_en) begin
      addr_d = addr_q + 16'd1;
    end
    rd_pend_d = read_en;

    // Read data is captured one cycle after the strobe even while stalled.
    if (rd_pend_q) begin
      if (state_q == StFill) begin
        cur_d     = iRamData;
        bit_idx_d = 4'd15;
        state_d   = StUnary;
      end else begin
        pf_d       = iRamData;
        pf_valid_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q    <= StIdle;
      k_q        <= '0;
      count_q    <= '0;
      emitted_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      bin_cnt_q  <= '0;
      cur_q      <= '0;
      bit_idx_q  <= '0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      addr_q     <= '0;
      residual_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      count_q    <= count_d;
      emitted_q  <= emitted_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      bin_cnt_q  <= bin_cnt_d;
      cur_q      <= cur_d;
      bit_idx_q  <= bit_idx_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      rd_pend_q  <= rd_pend_d;
      addr_q     <= addr_d;
      residual_q <= residual_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  assign oRamReadEnable = read_en;
  assign oRamAddress    = addr_q;
  assign oResidual      = residual_q;
  assign oValid         = valid_q & iEnable;
  assign oDone          = (state_q == StDone) & iEnable;
  assign oError         = error_q;

endmodule

// File: tb/tb_rice_stream_decoder.sv
// Bench for rice_stream_decoder: bit-level reference decoder over a RAM image,
// cycle-accurate event prediction, directed corner cases and random runs.
module tb_rice_stream_decoder;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iEnable;
  logic        iStart;
  logic [3:0]  iRiceParam;
  logic [15:0] iCount;
  logic        oRamReadEnable;
  logic [15:0] oRamAddress;
  logic [15:0] iRamData;
  logic [15:0] oResidual;
  logic        oValid;
  logic        oDone;
  logic        oError;

  rice_stream_decoder dut (
    .iClock        (iClock),
    .iReset        (iReset),
    .iEnable       (iEnable),
    .iStart        (iStart),
    .iRiceParam    (iRiceParam),
    .iCount        (iCount),
    .oRamReadEnable(oRamReadEnable),
    .oRamAddress   (oRamAddress),
    .iRamData      (iRamData),
    .oResidual     (oResidual),
    .oValid        (oValid),
    .oDone         (oDone),
    .oError        (oError)
  );

  always #5 iClock = ~iClock;

  logic [15:0] mem [0:127];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_res[$];
  int          exp_cyc[$];
  int          m_e[$];
  int          m_bits;
  bit          m_err;
  int          reads_seen, done_seen, done_cyc;
  bit          chk_on = 1'b1;
  bit          timing_on = 1'b0;
  int          en_mode = 0;
  int          stall_s = -100;
  logic [15:0] got[$];
  logic [15:0] er;
  int          ec;

  always @(posedge iClock) cyc <= cyc + 1;

  // RAM: data valid the cycle after the strobe.
  always @(posedge iClock) if (oRamReadEnable) iRamData <= mem[oRamAddress[6:0]];

  // Enable: random, or high except a 3-cycle stall window.
  always @(posedge iClock) begin
    #1;
    if (en_mode == 1) iEnable = ($urandom_range(0, 3) != 0);
    else iEnable = !(cyc >= stall_s && cyc < stall_s + 3);
  end

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int bit_at(input int p);
    logic [15:0] w;
    w = mem[(p / 16) % 128];
    return int'(w[15 - (p % 16)]);
  endfunction

  // Reference decoder over the flat bit string.
  task automatic model(input int k, input int count);
    int pos, q, rem, u, r, lim;
    exp_res.delete();
    m_e.delete();
    m_err  = 1'b0;
    m_bits = 0;
    pos    = 0;
    if (k == 15) begin
      m_err = 1'b1;
      return;
    end
    lim = 1 << (16 - k);
    for (int i = 0; i < count; i++) begin
      q = 0;
      while (bit_at(pos) == 0) begin
        pos++;
        q++;
        if (q == lim) begin
          m_err  = 1'b1;
          m_bits = pos;
          return;
        end
      end
      pos++;
      rem = 0;
      for (int j = 0; j < k; j++) begin
        rem = rem * 2 + bit_at(pos);
        pos++;
      end
      u = ((q << k) + rem) % 65536;
      r = (u % 2 == 1) ? -(u / 2) - 1 : u / 2;
      exp_res.push_back(r[15:0]);
      m_e.push_back(pos);
    end
    m_bits = pos;
  endtask

  // Per-cycle compare against the model's predicted stream.
  always @(negedge iClock) begin
    if (iReset && chk_on) begin
      if (oValid) begin
        got.push_back(oResidual);
        if (exp_res.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          er = exp_res.pop_front();
          ec = exp_cyc.pop_front();
          chk("residual", int'(oResidual), int'(er));
          if (timing_on) chk("valid_cycle", cyc, ec);
        end
      end
      if (oRamReadEnable) begin
        chk("read_addr", int'(oRamAddress), reads_seen);
        reads_seen++;
      end
      if (oDone) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run(input int k, input int count, input int mode, input bit tim,
                     input int stall_at, input bit poke);
    int s, n, exp_done, exp_reads, t;
    model(k, count);
    reads_seen = 0;
    done_seen  = 0;
    got.delete();
    exp_cyc.delete();
    timing_on = 1'b0;
    @(negedge iClock);
    iStart     = 1'b1;
    iRiceParam = 4'(k);
    iCount     = 16'(count);
    @(posedge iClock);
    #1;
    s      = cyc;
    iStart = 1'b0;
    chk("error_at_start", int'(oError), (k == 15) ? 1 : 0);
    if (stall_at > 0) stall_s = s + stall_at;
    foreach (m_e[i]) begin
      t = s + 2 + m_e[i];
      if (stall_at > 0 && t >= s + stall_at) t += 3;
      exp_cyc.push_back(t);
    end
    if (k == 15 || count == 0) begin
      exp_done  = s;
      exp_reads = 0;
    end else begin
      exp_reads = (m_bits + 15) / 16 + 1;
      exp_done  = m_err ? s + 2 + m_bits : s + 3 + m_bits;
    end
    if (stall_at > 0 && exp_done >= s + stall_at) exp_done += 3;
    timing_on = tim;
    en_mode   = mode;
    n = 0;
    while (done_seen == 0 && n < 4000) begin
      @(negedge iClock);
      n++;
      // A start pulse mid-run must be ignored.
      iStart = poke && (cyc == s + 4);
      iCount = (poke && cyc == s + 4) ? 16'd0 : 16'(count);
    end
    iStart = 1'b0;
    if (done_seen == 0) chk("done_timeout", 0, 1);
    repeat (3) @(negedge iClock);
    en_mode = 0;
    stall_s = -100;
    chk("missing_valid", exp_res.size(), 0);
    chk("done_pulses", done_seen, 1);
    if (tim) chk("done_cycle", done_cyc, exp_done);
    chk("error_flag", int'(oError), int'(m_err));
    chk("read_count", reads_seen, exp_reads);
  endtask

  initial begin
    iReset     = 1'b0;
    iEnable    = 1'b1;
    iStart     = 1'b0;
    iRiceParam = '0;
    iCount     = '0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    repeat (3) @(negedge iClock);
    chk("rst_ctl", int'({oValid, oDone, oError, oRamReadEnable}), 0);
    chk("rst_addr", int'(oRamAddress), 0);
    chk("rst_res", int'(oResidual), 0);
    iReset = 1'b1;
    repeat (2) @(negedge iClock);

    // Full-word decode, with an ignored mid-run start.
    mem[0] = 16'h8420;
    model(5, 2);
    chk("model_s1_r0", int'(exp_res[0]), 16'hFFFF);
    chk("model_s1_r1", int'(exp_res[1]), 16'h0040);
    chk("model_s1_e0", m_e[0], 6);
    chk("model_s1_e1", m_e[1], 16);
    run(5, 2, 0, 1'b1, 0, 1'b1);
    chk("s1_nvalid", got.size(), 2);
    if (got.size() == 2) begin
      chk("s1_got0", int'(got[0]), 16'hFFFF);
      chk("s1_got1", int'(got[1]), 16'h0040);
    end

    // Word boundary with k = 0.
    mem[0] = 16'hFFFF;
    mem[1] = 16'h8000;
    run(0, 17, 0, 1'b1, 0, 1'b0);
    chk("s2_nvalid", got.size(), 17);
    chk("s2_reads", reads_seen, 3);

    // Quotient overflow; error stays sticky.
    for (int i = 0; i < 128; i++) mem[i] = '0;
    run(14, 3, 0, 1'b1, 0, 1'b0);
    chk("ovf_bits", m_bits, 4);
    chk("ovf_nvalid", got.size(), 0);
    repeat (5) @(negedge iClock);
    chk("ovf_sticky", int'(oError), 1);

    // Degenerate starts.
    run(5, 0, 0, 1'b1, 0, 1'b0);
    chk("cnt0_err", int'(oError), 0);
    run(15, 3, 0, 1'b1, 0, 1'b0);
    chk("k15_err", int'(oError), 1);

    // Stalls: during an outstanding read, then mid-BIN.
    mem[0] = 16'h8420;
    run(5, 2, 0, 1'b1, 2, 1'b0);
    if (got.size() == 2) chk("stall_a_got1", int'(got[1]), 16'h0040);
    run(5, 2, 0, 1'b1, 5, 1'b0);
    if (got.size() == 2) chk("stall_b_got0", int'(got[0]), 16'hFFFF);

    // Reset mid-run.
    chk_on = 1'b0;
    @(negedge iClock);
    iStart     = 1'b1;
    iRiceParam = 4'd5;
    iCount     = 16'd2;
    @(posedge iClock);
    #1;
    iStart = 1'b0;
    repeat (11) @(negedge iClock);
    iReset = 1'b0;
    #1;
    chk("midrst_ctl", int'({oValid, oDone, oError, oRamReadEnable}), 0);
    chk("midrst_addr", int'(oRamAddress), 0);
    chk("midrst_res", int'(oResidual), 0);
    @(negedge iClock);
    iReset = 1'b1;
    chk_on = 1'b1;
    @(negedge iClock);
    run(5, 2, 0, 1'b1, 0, 1'b0);
    if (got.size() == 2) chk("post_rst_got1", int'(got[1]), 16'h0040);

    // Random streams: exact timing with enable high, then random enable.
    for (int t = 0; t < 45; t++) begin
      for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
      run($urandom_range(0, 14), $urandom_range(1, 20), (t >= 30) ? 1 : 0, (t < 30), 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
